// File: rtl/cla_addsub_pipe_16bits.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 resolves the low half and captures the inter-half carry. Stage 2
// resolves the high half from that carry and registers the result and flags.
//
// Handshake: a beat transfers on any rising edge where valid && ready are both
// high. A producer holds its payload stable while valid is high and ready is
// low. ready never depends on the same side's valid. in_ready depends only on
// pipeline occupancy and out_ready.
module cla_addsub_pipe_16bits #(
  parameter int WIDTH = 16,
  parameter int LOW_W = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             CoBo,
  output logic             Ovf,
  output logic             Zero
);

  localparam int HIGH_W = WIDTH - LOW_W;
  localparam int MAX_W  = (LOW_W > HIGH_W) ? LOW_W : HIGH_W;
  localparam int NG     = (MAX_W + 3) / 4;
  localparam int PW     = 4 * NG;

  // Lookahead adder over 4-bit groups. Bits at or above w are padded as
  // propagate-only, so the final group carry is the carry out of bit w-1.
  // Returns {carry_out, sum}.
  function automatic logic [PW:0] cla_block(input logic [PW-1:0] a,
                                            input logic [PW-1:0] b,
                                            input logic          cin,
                                            input int            w);
    logic [PW-1:0] g, p, c;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          t;
    for (int i = 0; i < PW; i++) begin
      g[i] = (i < w) ? (a[i] & b[i]) : 1'b0;
      p[i] = (i < w) ? (a[i] ^ b[i]) : 1'b1;
    end
    // group generate / propagate
    for (int k = 0; k < NG; k++) begin
      gg[k] = 1'b0;
      gp[k] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        t = g[4*k+i];
        for (int j = i + 1; j < 4; j++) t = t & p[4*k+j];
        gg[k] = gg[k] | t;
        gp[k] = gp[k] & p[4*k+i];
      end
    end
    // group carries, each as a flat sum of products
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      t = cin;
      for (int n = 0; n <= k; n++) t = t & gp[n];
      gc[k+1] = t;
      for (int m = 0; m <= k; m++) begin
        t = gg[m];
        for (int n = m + 1; n <= k; n++) t = t & gp[n];
        gc[k+1] = gc[k+1] | t;
      end
    end
    // bit carries inside each group from the group carry-in
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 4; i++) begin
        t = gc[k];
        for (int j = 0; j < i; j++) t = t & p[4*k+j];
        c[4*k+i] = t;
        for (int j = 0; j < i; j++) begin
          t = g[4*k+j];
          for (int n = j + 1; n < i; n++) t = t & p[4*k+n];
          c[4*k+i] = c[4*k+i] | t;
        end
      end
    end
    return {gc[NG], p ^ c};
  endfunction

  // pipeline registers
  logic              s1_valid_q;
  logic [LOW_W-1:0]  s1_sum_lo_q;
  logic              s1_c_q;
  logic [HIGH_W-1:0] s1_a_hi_q;
  logic [HIGH_W-1:0] s1_bx_hi_q;
  logic              s1_sub_q;
  logic              s2_valid_q;
  logic [WIDTH-1:0]  s_q;
  logic              cobo_q, ovf_q, zero_q;

  logic              s1_adv, s2_adv;
  logic [WIDTH-1:0]  bx;
  logic              c0;
  logic [PW:0]       lo_res, hi_res;
  logic [WIDTH-1:0]  s_d;
  logic              cout, cobo_d, ovf_d, zero_d;
  logic              a_msb, bx_msb;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Subtraction is A + ~B + ~Bin, so a borrow-in removes the +1.
  assign bx     = sub ? ~B : B;
  assign c0     = sub ? ~Bin : Bin;
  assign lo_res = cla_block(PW'(A[LOW_W-1:0]), PW'(bx[LOW_W-1:0]), c0, LOW_W);

  // The operand sign bits travel as the top bits of the registered high halves.
  assign a_msb  = s1_a_hi_q[HIGH_W-1];
  assign bx_msb = s1_bx_hi_q[HIGH_W-1];
  assign hi_res = cla_block(PW'(s1_a_hi_q), PW'(s1_bx_hi_q), s1_c_q, HIGH_W);
  assign s_d    = {hi_res[HIGH_W-1:0], s1_sum_lo_q};
  assign cout   = hi_res[PW];
  assign cobo_d = s1_sub_q ? ~cout : cout;
  assign ovf_d  = (a_msb == bx_msb) && (s_d[WIDTH-1] != a_msb);
  assign zero_d = (s_d == '0);

  // Stage 1: capture the resolved low half and the high-half operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sum_lo_q <= '0;
      s1_c_q      <= 1'b0;
      s1_a_hi_q   <= '0;
      s1_bx_hi_q  <= '0;
      s1_sub_q    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sum_lo_q <= lo_res[LOW_W-1:0];
        s1_c_q      <= lo_res[PW];
        s1_a_hi_q   <= A[WIDTH-1:LOW_W];
        s1_bx_hi_q  <= bx[WIDTH-1:LOW_W];
        s1_sub_q    <= sub;
      end
    end
  end

  // Stage 2: register the full result and flags; hold them under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s_q        <= '0;
      cobo_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s_q    <= s_d;
        cobo_q <= cobo_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign S         = s_q;
  assign CoBo      = cobo_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe_16bits.sv
// Bench for the pipelined CLA adder/subtractor: directed vectors, streaming,
// backpressure and mid-stream reset, with a queue scoreboard of results.
module tb_cla_addsub_pipe_16bits;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] A, B;
  logic        sub, Bin;
  logic        out_valid, out_ready;
  logic [15:0] S;
  logic        CoBo, Ovf, Zero;

  int checks   = 0;
  int failures = 0;

  // {S, CoBo, Ovf, Zero}
  logic [18:0] exp_q[$];

  cla_addsub_pipe_16bits #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .Bin(Bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .CoBo(CoBo), .Ovf(Ovf), .Zero(Zero)
  );

  // Reference: plain wide arithmetic on the architectural definition.
  function automatic logic [18:0] model(input logic s, input logic [15:0] a,
                                        input logic [15:0] b, input logic bin);
    logic [15:0] bx;
    logic [16:0] sum;
    logic        cin, co, ovf;
    bx  = s ? ~b : b;
    cin = s ? ~bin : bin;
    sum = {1'b0, a} + {1'b0, bx} + {16'b0, cin};
    co  = sum[16];
    ovf = (a[15] == bx[15]) && (sum[15] != a[15]);
    return {sum[15:0], (s ? ~co : co), ovf, (sum[15:0] == 16'h0)};
  endfunction

  // Scoreboard: pops one expectation per output transfer.
  task automatic monitor_loop();
    logic [18:0] exp_v, got;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        got = {S, CoBo, Ovf, Zero};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_extra got=%h expected none", got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            failures++;
            $display("FAIL scoreboard got={S,CoBo,Ovf,Zero}=%h expected=%h", got, exp_v);
          end
        end
      end
    end
  endtask

  // Driver: present a beat, wait for the accept edge, push its expectation.
  task automatic drive_beat(input logic s, input logic [15:0] a,
                            input logic [15:0] b, input logic bin);
    bit ok;
    int budget;
    sub = s; A = a; B = b; Bin = bin; in_valid = 1'b1;
    ok = 1'b0;
    budget = 0;
    while (!ok && budget < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      budget++;
    end
    if (ok) exp_q.push_back(model(s, a, b, bin));
    else begin
      checks++;
      failures++;
      $display("FAIL drive_beat_timeout in_ready=%b expected 1", in_ready);
    end
    #1;
  endtask

  task automatic drain(input string name);
    int budget;
    in_valid = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while ((exp_q.size() != 0 || out_valid) && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d out_valid=%b expected 0/0", name, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = 16'h0; B = 16'h0; sub = 1'b0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (S !== 16'h0) begin failures++; $display("FAIL reset_S got=%h exp=0000", S); end
    checks++; if ({CoBo, Ovf, Zero} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {CoBo, Ovf, Zero}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_out_valid got=%b exp=0", out_valid); end
  endtask

  // Directed vectors with hand-computed results and latency checks.
  task automatic test_directed();
    logic [52:0] vec[8];
    logic [52:0] v;
    vec[0] = {1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 3'b000};
    vec[1] = {1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 3'b100};
    vec[2] = {1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 3'b010};
    vec[3] = {1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 3'b000};
    vec[4] = {1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 3'b101};
    vec[5] = {1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 3'b010};
    vec[6] = {1'b1, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 3'b100};
    vec[7] = {1'b1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 3'b001};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = vec[i];
      drive_beat(v[52], v[51:36], v[35:20], v[19]);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL directed%0d_early out_valid=%b exp=0", i, out_valid); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL directed%0d_latency out_valid=%b exp=1", i, out_valid); end
      checks++;
      if ({S, CoBo, Ovf, Zero} !== v[18:0]) begin
        failures++;
        $display("FAIL directed%0d_result got=%h/%b expected=%h/%b", i, S, {CoBo, Ovf, Zero}, v[18:3], v[2:0]);
      end
    end
    drain("directed");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_beat(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      checks++;
      if (out_valid !== (i >= 1)) begin failures++; $display("FAIL b2b_valid_beat%0d got=%b exp=%b", i, out_valid, (i >= 1)); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_last_valid got=%b exp=1", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_bubble got=%b exp=0", out_valid); end
    drain("b2b");
  endtask

  task automatic test_backpressure();
    logic [15:0] hold_s;
    out_ready = 1'b0;
    drive_beat(1'b0, 16'h1234, 16'h1111, 1'b0);
    drive_beat(1'b1, 16'h0100, 16'h0200, 1'b1);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
    hold_s = S;
    checks++; if (hold_s !== 16'h2345) begin failures++; $display("FAIL bp_head_S got=%h exp=2345", hold_s); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (S !== hold_s || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d S=%h valid=%b in_ready=%b exp S=%h valid=1 in_ready=0", i, S, out_valid, in_ready, hold_s);
      end
    end
    out_ready = 1'b1;
    drive_beat(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    drain("bp");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_beat(1'b0, 16'h0AAA, 16'h0555, 1'b0);
    drive_beat(1'b1, 16'h0F00, 16'h00F0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale got=%b exp=0", out_valid); end
    drive_beat(1'b0, 16'h1234, 16'h4321, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || S !== 16'h5555) begin
      failures++;
      $display("FAIL rstmid_first valid=%b S=%h exp valid=1 S=5555", out_valid, S);
    end
    drain("rstmid");
  endtask

  initial begin
    rst_n = 1'b0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
